// File: rtl/math_op_sched_if.sv
// Request/result bus of math_op_sched: per-requester operand inputs with a ready
// grant, and a tagged valid/ready result return.
interface math_op_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0][31:0] req_a;
  logic [NUM_REQ-1:0][31:0] req_b;
  logic [NUM_REQ-1:0][31:0] req_c;
  logic                     res_valid;
  logic                     res_ready;
  logic [31:0]              res_data;
  logic [ID_W-1:0]          res_id;

  modport master (
    output req_valid, req_a, req_b, req_c, res_ready,
    input  req_ready, res_valid, res_data, res_id
  );

  modport slave (
    input  req_valid, req_a, req_b, req_c, res_ready,
    output req_ready, res_valid, res_data, res_id
  );
endinterface

// File: rtl/math_op_sched.sv
// Shares one non-stallable math_op datapath (d = 3 + c*c*(a+b)) between NUM_REQ requesters.
// Define MATH_OP_SCHED_FIXED_PRIO_EN for strict lowest-index-first arbitration instead of round-robin.
module math_op_sched #(
  parameter int NUM_REQ    = 4,
  parameter int ID_W       = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  math_op_sched_if.slave       bus,
  output logic [31:0]          op_a,
  output logic [31:0]          op_b,
  output logic [31:0]          op_c,
  input  logic [31:0]          op_d,
  output logic                 busy
);
  localparam int STAGES = 3;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  typedef struct packed {
    logic [31:0]     a;
    logic [31:0]     b;
    logic [31:0]     c;
    logic [ID_W-1:0] id;
  } req_t;

  typedef struct packed {
    logic [31:0]     data;
    logic [ID_W-1:0] id;
  } res_t;

  logic            gnt_vld;
  logic [ID_W-1:0] gnt_id;
  logic            credit;
  logic            hs;

  logic [STAGES:1] vld_pipe_q;
  req_t            s1_q;
  logic [31:0]     s2_a_q, s2_b_q;
  logic [ID_W-1:0] s2_id_q, s3_id_q;

  res_t             mem_q [FIFO_DEPTH];
  res_t             rd_ent;
  logic [CNT_W-1:0] wr_q, rd_q, fifo_cnt;
  logic [CNT_W:0]   used;
  logic             push, pop, empty, full;

  // ---------------- arbitration ----------------
`ifdef MATH_OP_SCHED_FIXED_PRIO_EN
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        gnt_vld = 1'b1;
        gnt_id  = ID_W'(i);
      end
    end
  end
`else
  logic [ID_W-1:0] rr_q, rr_d;

  // Scan farthest-first so the nearest valid requester after rr_q is written last.
  always_comb begin
    logic [ID_W:0] sum;
    sum     = '0;
    gnt_vld = 1'b0;
    gnt_id  = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      sum = {1'b0, rr_q} + (ID_W+1)'(k);
      if (sum >= (ID_W+1)'(NUM_REQ)) sum = sum - (ID_W+1)'(NUM_REQ);
      if (bus.req_valid[sum[ID_W-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_id  = sum[ID_W-1:0];
      end
    end
  end

  assign rr_d = hs ? gnt_id : rr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_q <= ID_W'(NUM_REQ - 1);
    else        rr_q <= rr_d;
  end
`endif

  // Every op in flight already owns a FIFO slot; a pop this cycle frees nothing yet.
  assign used   = {1'b0, fifo_cnt} + (CNT_W+1)'(vld_pipe_q[1]) + (CNT_W+1)'(vld_pipe_q[2])
                + (CNT_W+1)'(vld_pipe_q[3]);
  assign credit = used < (CNT_W+1)'(FIFO_DEPTH);
  assign hs     = gnt_vld & credit;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign bus.req_ready[i] = hs && (gnt_id == ID_W'(i));
  end

  // ---------------- tag / operand pipeline ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      s1_q       <= '0;
      s2_a_q     <= '0;
      s2_b_q     <= '0;
      s2_id_q    <= '0;
      s3_id_q    <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[STAGES-1:1], hs};
      if (hs) s1_q <= {bus.req_a[gnt_id], bus.req_b[gnt_id], bus.req_c[gnt_id], gnt_id};
      if (vld_pipe_q[1]) begin
        s2_a_q  <= s1_q.a;
        s2_b_q  <= s1_q.b;
        s2_id_q <= s1_q.id;
      end
      if (vld_pipe_q[2]) s3_id_q <= s2_id_q;
    end
  end

  // c leads a/b by one cycle to match the datapath's internal c*c register.
  assign op_c = vld_pipe_q[1] ? s1_q.c : '0;
  assign op_a = vld_pipe_q[2] ? s2_a_q : '0;
  assign op_b = vld_pipe_q[2] ? s2_b_q : '0;

  // ---------------- result FIFO ----------------
  assign push     = vld_pipe_q[3];
  assign empty    = (wr_q == rd_q);
  assign fifo_cnt = wr_q - rd_q;
  assign full     = (fifo_cnt == CNT_W'(FIFO_DEPTH));
  assign pop      = !empty && bus.res_ready;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[PTR_W-1:0]] <= {op_d, s3_id_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
    end
  end

  assign rd_ent        = mem_q[rd_q[PTR_W-1:0]];
  assign bus.res_valid = !empty;
  assign bus.res_data  = empty ? '0 : rd_ent.data;
  assign bus.res_id    = empty ? '0 : rd_ent.id;
  assign busy          = (|vld_pipe_q) | !empty;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));
endmodule

// File: doc/math_op_sched.md
Name: math_op_sched

Overview:
- Shares one `math_op` datapath instance, d = 3 + c*c*(a+b) with a 2-register pipeline, between NUM_REQ requesters.
- Arbitrates requests round-robin and applies the datapath's operand skew: c is presented one cycle before a/b.
- Tracks in-flight operations with a tag pipeline and buffers results in a FIFO.
- Returns each result tagged with the requester id over a valid/ready port, so the non-stallable datapath never loses a result.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of requester id; must equal clog2(NUM_REQ).
- FIFO_DEPTH, 8, result FIFO entries; power of 2, minimum 4.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high.
- req_a  in  32*NUM_REQ  signed operand a; requester i occupies bits [32i+31:32i].
- req_b  in  32*NUM_REQ  signed operand b, same packing.
- req_c  in  32*NUM_REQ  signed operand c, same packing.
- op_a  out  32  operand a to datapath.
- op_b  out  32  operand b to datapath.
- op_c  out  32  operand c to datapath.
- op_d  in  32  datapath result.
- res_valid  out  1  result available.
- res_ready  in  1  result consumer accept.
- res_data  out  32  signed result.
- res_id  out  ID_W  requester that issued this result.
- busy  out  1  any stage valid or FIFO non-empty.

Behaviour:
- Reset: all outputs 0, stages invalid, FIFO empty, RR pointer = NUM_REQ-1 (so requester 0 wins first). Reset mid-operation discards in-flight work and FIFO contents.
- Credit: issue allowed only when (s1_v+s2_v+s3_v) + fifo_count < FIFO_DEPTH. A same-cycle FIFO pop is not credited.
- Arbitration:
  - Combinational. Grant the first valid requester searching from (last_grant+1) mod NUM_REQ.
  - req_ready[g]=1 only when credit is available; the handshake is req_valid[g] & req_ready[g].
  - The RR pointer updates to g only on a handshake.
- Pipeline: handshake in cycle k.
  - Edge k+1: stage s1 captures {a,b,c,id}, s1_v=1. op_c = s1_c in cycle k+1.
  - Edge k+2: s2 captures {a,b,id} from s1. op_a/op_b = s2_a/s2_b in cycle k+2.
  - Edge k+3: s3_v/s3_id follow s2. op_d holds the result in cycle k+3.
  - Edge k+4: when s3_v, {op_d, s3_id} is written to the FIFO. Earliest res_valid is cycle k+4 (4-cycle latency).
- Idle operands: op_c=0 when !s1_v; op_a/op_b=0 when !s2_v.
- Throughput: 1 op/cycle sustained with res_ready=1. Stages never stall.
- FIFO:
  - res_valid = !empty; pop on res_valid & res_ready.
  - Simultaneous push and pop allowed, including when full-1 or empty-with-push (no bypass: a write to an empty FIFO is visible the next cycle).
  - Overflow is impossible by construction; an assertion flags a push while full.
  - Results are returned in issue order.
- Arithmetic is performed by the datapath: 32-bit two's-complement wrap, no saturation. The scheduler passes data unchanged.
- busy = s1_v|s2_v|s3_v|!empty.

Optional Feature:
- MATH_OP_SCHED_FIXED_PRIO_EN defined: strict priority, lowest index wins; RR pointer logic is removed.
- Undefined: round-robin as above.
- All other timing is identical in both modes.

Test Plan:
- Req0 a=1,b=2,c=3, res_ready=1 -> op_c=3 at k+1, op_a=1/op_b=2 at k+2, res_data=30, res_id=0 at cycle k+4, busy low after the pop.
- All 4 requesters valid continuously -> grant order 0,1,2,3,0,1,...; one result per cycle with ids in the same order.
- res_ready=0 with req0 always valid -> exactly 8 handshakes, then req_ready=0. Release res_ready -> 8 results in order, then issue resumes; no loss or duplicate.
- a=0x7FFFFFFF, b=1, c=2 -> res_data=3 (wrap). a=-5, b=2, c=-4 -> res_data=-45.
- Assert rst_n low with 3 ops in flight and FIFO half full -> res_valid=0, busy=0, all outputs 0 immediately. After release, req1 and req0 both valid -> req0 granted first.
- With MATH_OP_SCHED_FIXED_PRIO_EN, req0 and req2 valid continuously -> req2 is never granted while req0 stays valid.
